// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - received-byte bus between the UART receiver and its consumer
//
// Carries the recovered byte and its strobes.
//   rx_data   : last correctly framed byte, held until the next good frame
//   rx_done   : one-cycle strobe, rx_data is new in this cycle
//   frame_err : one-cycle strobe, stop bit was low and the frame was dropped
// master = receiver (drives), slave = consumer (observes).
interface uart_byte_rx_if;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;

   modport master (output rx_data, output rx_done, output frame_err);
   modport slave  (input  rx_data, input  rx_done, input  frame_err);
endinterface

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART receiver with mid-bit majority sampling
//
// Recovers LSB-first 8N1 bytes from an idle-high line; 50 MHz clock.
//   sys_clk  : system clock
//   rst_n    : asynchronous active-low reset
//   time_set : baud select, 0 -> 4800, 1 -> 9600, other -> 115200
//   uart_rx  : asynchronous serial input
//   rx_bus   : received byte plus rx_done / frame_err strobes (master side)
module uart_byte_rx (
   input  logic           sys_clk,
   input  logic           rst_n,
   input  logic [2:0]     time_set,
   input  logic           uart_rx,
   uart_byte_rx_if.master rx_bus
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state, state_nxt;
   logic        sync1, rx_s, rx_d;
   logic [1:0]  flush;
   logic        armed, armed_nxt;
   logic [13:0] n_sel, n_lat, n_nxt, half;
   logic [13:0] cnt, cnt_nxt;
   logic [2:0]  bit_idx, bit_idx_nxt;
   logic [7:0]  shreg, shreg_nxt, data_r, data_nxt;
   logic        s0, s1;
   logic        done_r, done_nxt, ferr_r, ferr_nxt;
   logic        fall, maj, at_wrap, at_decide;

   always_comb begin
      case (time_set)
         3'd0:    n_sel = 14'd10416;
         3'd1:    n_sel = 14'd5208;
         default: n_sel = 14'd434;
      endcase
   end

   // Synchronizer plus edge-detect delay, all idle-high out of reset.
   // flush marks when rx_s holds a real pin sample instead of its reset
   // value, so a line that is low at reset release is not seen as a start edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
         flush <= 2'b00;
      end else begin
         sync1 <= uart_rx;
         rx_s  <= sync1;
         rx_d  <= rx_s;
         flush <= {flush[0], 1'b1};
      end
   end

   assign fall      = rx_d & ~rx_s;
   assign half      = n_lat >> 1;
   assign at_wrap   = (cnt == n_lat - 14'd1);
   assign at_decide = (cnt == half + 14'd1);
   // Third sample is the live rx_s at the decision point.
   assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

   always_comb begin
      state_nxt   = state;
      armed_nxt   = armed;
      n_nxt       = n_lat;
      cnt_nxt     = at_wrap ? 14'd0 : cnt + 14'd1;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      data_nxt    = data_r;
      done_nxt    = 1'b0;
      ferr_nxt    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = 14'd0;
            if (fall && armed) begin
               // The edge cycle itself counts as cnt=0 of the start bit.
               state_nxt   = START;
               armed_nxt   = 1'b0;
               n_nxt       = n_sel;
               cnt_nxt     = 14'd1;
               bit_idx_nxt = 3'd0;
            end else if (rx_s && flush[1]) begin
               armed_nxt = 1'b1;
            end
         end
         START: begin
            if (at_decide && maj) begin
               state_nxt = IDLE;
               cnt_nxt   = 14'd0;
            end else if (at_wrap) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (at_decide)
               shreg_nxt[bit_idx] = maj;
            if (at_wrap) begin
               if (bit_idx == 3'd7)
                  state_nxt = STOP;
               else
                  bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         STOP: begin
            // Leave at the mid-bit decision so a slightly short stop bit
            // still lets the next start edge be caught.
            if (at_decide) begin
               state_nxt = IDLE;
               cnt_nxt   = 14'd0;
               // A low stop bit leaves us disarmed until the line goes high,
               // so a held break yields a single frame_err.
               armed_nxt = maj;
               if (maj) begin
                  data_nxt = shreg;
                  done_nxt = 1'b1;
               end else begin
                  ferr_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         armed   <= 1'b0;
         n_lat   <= 14'd434;
         cnt     <= 14'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
         data_r  <= 8'h00;
         done_r  <= 1'b0;
         ferr_r  <= 1'b0;
         s0      <= 1'b1;
         s1      <= 1'b1;
      end else begin
         state   <= state_nxt;
         armed   <= armed_nxt;
         n_lat   <= n_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
         data_r  <= data_nxt;
         done_r  <= done_nxt;
         ferr_r  <= ferr_nxt;
         if (cnt == half - 14'd1)
            s0 <= rx_s;
         if (cnt == half)
            s1 <= rx_s;
      end
   end

   assign rx_bus.rx_data   = data_r;
   assign rx_bus.rx_done   = done_r;
   assign rx_bus.frame_err = ferr_r;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - directed self-checking bench for uart_byte_rx
module tb_uart_byte_rx;

   logic       sys_clk  = 1'b0;
   logic       rst_n    = 1'b0;
   logic [2:0] time_set = 3'd2;
   logic       uart_rx  = 1'b1;

   uart_byte_rx_if bus();

   uart_byte_rx dut (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .time_set (time_set),
      .uart_rx  (uart_rx),
      .rx_bus   (bus)
   );

   always #10 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] got_data[$];
   int         got_cyc[$];
   int         ferr_cnt = 0;
   int         ferr_cyc = 0;
   int         both_cnt = 0;

   // With the pin driven at cycle c0, rx_s falls at E=c0+2 and the strobe
   // appears at E+9N+M+2; for N=434 that is c0+4127.
   localparam int N115 = 434;
   localparam int FRAME = 10 * N115;
   localparam int LAT = 2 + 9 * N115 + N115 / 2 + 2;

   always @(negedge sys_clk) begin
      if (bus.rx_done) begin
         got_data.push_back(bus.rx_data);
         got_cyc.push_back(cyc);
      end
      if (bus.frame_err) begin
         ferr_cnt = ferr_cnt + 1;
         ferr_cyc = cyc;
      end
      if (bus.rx_done && bus.frame_err)
         both_cnt = both_cnt + 1;
   end

   initial begin
      #(20 * 100000);
      $display("FAIL watchdog cycle budget exhausted at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Drives an 8N1 frame from a negedge, one pin value per cycle; glitch_at
   // inverts the line for one cycle, limit truncates the frame.
   task automatic send_frame(input logic [7:0] b, input int n, input logic stop,
                             input int glitch_at, input int limit, output int c0);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      c0   = cyc;
      for (int i = 0; i < limit; i++) begin
         uart_rx = bits[i / n] ^ (i == glitch_at);
         @(negedge sys_clk);
      end
   endtask

   task automatic clear_log();
      got_data.delete();
      got_cyc.delete();
      ferr_cnt = 0;
   endtask

   task automatic expect_one(input string tag, input logic [7:0] exp, input int c0);
      check_eq({tag, "_count"}, got_data.size(), 1);
      if (got_data.size() > 0) begin
         check_eq({tag, "_data"}, got_data[0], exp);
         check_eq({tag, "_lat"}, got_cyc[0] - c0, LAT);
      end
      check_eq({tag, "_hold"}, bus.rx_data, exp);
      check_eq({tag, "_ferr"}, ferr_cnt, 0);
   endtask

   int c0, c1, c2;
   logic [7:0] b2b[3];

   initial begin
      idle(4);
      check_eq("rst_data", bus.rx_data, 8'h00);
      check_eq("rst_done", bus.rx_done, 1'b0);
      check_eq("rst_ferr", bus.frame_err, 1'b0);
      rst_n = 1'b1;
      idle(20);

      // single byte at 115200
      clear_log();
      send_frame(8'hA5, N115, 1'b1, -1, FRAME, c0);
      idle(20);
      expect_one("a5", 8'hA5, c0);

      // three frames back to back
      clear_log();
      b2b = '{8'h3C, 8'h00, 8'hFF};
      send_frame(b2b[0], N115, 1'b1, -1, FRAME, c0);
      send_frame(b2b[1], N115, 1'b1, -1, FRAME, c1);
      send_frame(b2b[2], N115, 1'b1, -1, FRAME, c2);
      idle(20);
      check_eq("b2b_count", got_data.size(), 3);
      for (int i = 0; i < got_data.size() && i < 3; i++)
         check_eq($sformatf("b2b_data%0d", i), got_data[i], b2b[i]);
      if (got_cyc.size() == 3)
         check_eq("b2b_last_lat", got_cyc[2] - c2, LAT);

      // start glitch, then a valid byte
      clear_log();
      uart_rx = 1'b0;
      idle(100);
      uart_rx = 1'b1;
      idle(700);
      check_eq("glitch_done", got_data.size(), 0);
      check_eq("glitch_ferr", ferr_cnt, 0);
      send_frame(8'h5A, N115, 1'b1, -1, FRAME, c0);
      idle(20);
      expect_one("5a", 8'h5A, c0);

      // one-cycle inversion on the cnt=M sample of bit 3
      clear_log();
      send_frame(8'h81, N115, 1'b1, 4 * N115 + N115 / 2, FRAME, c0);
      idle(20);
      expect_one("81", 8'h81, c0);

      // good byte, bad stop bit, then a held break
      clear_log();
      send_frame(8'h11, N115, 1'b1, -1, FRAME, c0);
      send_frame(8'h22, N115, 1'b0, -1, FRAME, c1);
      idle(3 * FRAME);
      uart_rx = 1'b1;
      idle(100);
      check_eq("brk_ferr_count", ferr_cnt, 1);
      check_eq("brk_ferr_lat", ferr_cyc - c1, LAT);
      check_eq("brk_done_count", got_data.size(), 1);
      check_eq("brk_hold", bus.rx_data, 8'h11);
      clear_log();
      send_frame(8'h33, N115, 1'b1, -1, FRAME, c0);
      idle(20);
      expect_one("33", 8'h33, c0);

      // reset in the middle of bit 4 (line low), released with the line low
      clear_log();
      send_frame(8'h0F, N115, 1'b1, -1, 5 * N115 + N115 / 2, c0);
      rst_n = 1'b0;
      idle(3);
      check_eq("midrst_data", bus.rx_data, 8'h00);
      check_eq("midrst_done", bus.rx_done, 1'b0);
      check_eq("midrst_ferr", bus.frame_err, 1'b0);
      idle(3);
      rst_n = 1'b1;
      idle(1000);
      uart_rx = 1'b1;
      idle(1000);
      check_eq("midrst_no_done", got_data.size(), 0);
      check_eq("midrst_no_ferr", ferr_cnt, 0);
      time_set = 3'd5;
      send_frame(8'h7E, N115, 1'b1, -1, FRAME, c0);
      idle(20);
      expect_one("7e", 8'h7E, c0);

      // slower baud codes reject pulses that a 434-cycle bit would accept
      clear_log();
      time_set = 3'd1;
      uart_rx  = 1'b0;
      idle(1500);
      uart_rx = 1'b1;
      idle(3000);
      check_eq("b9600_done", got_data.size(), 0);
      check_eq("b9600_ferr", ferr_cnt, 0);
      time_set = 3'd0;
      uart_rx  = 1'b0;
      idle(3000);
      uart_rx = 1'b1;
      idle(2600);
      check_eq("b4800_done", got_data.size(), 0);
      check_eq("b4800_ferr", ferr_cnt, 0);
      time_set = 3'd2;
      send_frame(8'h96, N115, 1'b1, -1, FRAME, c0);
      idle(20);
      expect_one("96", 8'h96, c0);

      check_eq("strobe_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
